// File: rtl/calc_mem_bridge_if.sv
// PS register port and PL calculator port of the shared operand/result memory.
interface calc_mem_bridge_if;
    logic        ps_wr_en;
    logic [7:0]  ps_addr;
    logic [31:0] ps_wdata;
    logic        ps_rd_en;
    logic [31:0] ps_rdata;
    logic        ps_start;
    logic        ps_clear;
    logic [2:0]  cmd;
    logic [7:0]  address_pl;
    logic [31:0] data_pl;
    logic [31:0] data_out;
    logic        done_pl;
    logic        ready;
    logic        busy;

    modport master (
        output ps_wr_en, ps_addr, ps_wdata, ps_rd_en, ps_start, ps_clear,
        output cmd, address_pl, data_pl, done_pl,
        input  ps_rdata, data_out, ready, busy
    );

    modport slave (
        input  ps_wr_en, ps_addr, ps_wdata, ps_rd_en, ps_start, ps_clear,
        input  cmd, address_pl, data_pl, done_pl,
        output ps_rdata, data_out, ready, busy
    );
endinterface

// File: rtl/calc_mem_bridge.sv
// Shared 32-bit word memory between the PS and the matrix calculator, with the
// load/arm/run/done sequencer that hands the memory to the calculator.
module calc_mem_bridge #(
    parameter int         DEPTH     = 256,
    parameter logic [7:0] OPND_ADDR = 8'd255,
    parameter int         N_INSTR   = 5
) (
    input  logic            clk,
    input  logic            rst,
    calc_mem_bridge_if.slave bus
);
    localparam int         MW     = N_INSTR + 1;
    localparam logic [2:0] CMD_WR = 3'd2;
    localparam logic [2:0] CMD_RD = 3'd3;

    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

    logic [31:0]   mem [DEPTH];
    state_t        state_reg, state_next;
    logic [MW-1:0] mask_reg, mask_next, slot_hit;
    logic          ready_reg, ready_next, busy_reg, busy_next;
    logic [31:0]   ps_rdata_reg, data_out_reg, status;
    logic          ps_wr_ok, ps_collide, pl_wr, pl_rd;

    // Address 0 is the read-only status word, never a storage location.
    assign ps_wr_ok   = bus.ps_wr_en && (state_reg != RUN) && (bus.ps_addr != 8'd0);
    assign pl_wr      = (bus.cmd == CMD_WR);
    assign pl_rd      = (bus.cmd == CMD_RD);
    assign ps_collide = pl_wr && (bus.address_pl == bus.ps_addr);

    generate
        for (genvar gi = 0; gi < N_INSTR; gi++) begin : g_slot
            assign slot_hit[gi] = (bus.ps_addr == 8'(gi + 1));
        end
    endgenerate
    assign slot_hit[N_INSTR] = (bus.ps_addr == OPND_ADDR);

    // Two write ports; on an address collision the calculator's word is kept.
    always_ff @(posedge clk) begin
        if (ps_wr_ok && !ps_collide)
            mem[bus.ps_addr] <= bus.ps_wdata;
        if (pl_wr)
            mem[bus.address_pl] <= bus.data_pl;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ps_rdata_reg <= '0;
            data_out_reg <= '0;
        end else begin
            if (bus.ps_rd_en)
                ps_rdata_reg <= (bus.ps_addr == 8'd0) ? status : mem[bus.ps_addr];
            if (pl_rd)
                data_out_reg <= mem[bus.address_pl];
        end
    end

    always_comb begin
        status         = '0;
        status[MW-1:0] = mask_reg;
        status[8]      = ready_reg;
        status[9]      = (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            mask_reg  <= '0;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            mask_reg  <= mask_next;
            ready_reg <= ready_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mask_next  = mask_reg;
        if (ps_wr_ok)
            mask_next = mask_reg | slot_hit;
        case (state_reg)
            IDLE:    if (mask_reg == '1)  state_next = ARMED;
            ARMED:   if (bus.ps_start)    state_next = RUN;
            RUN:     if (bus.done_pl)     state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
        // Clear overrides everything, including a simultaneous start.
        if (bus.ps_clear) begin
            state_next = IDLE;
            mask_next  = '0;
        end
    end

    // Outputs are registered from the next state so they assert on the cycle RUN is entered.
    always_comb begin
        ready_next = (state_next == RUN);
        busy_next  = (state_next == RUN);
    end

    assign bus.ready    = ready_reg;
    assign bus.busy     = busy_reg;
    assign bus.ps_rdata = ps_rdata_reg;
    assign bus.data_out = data_out_reg;
endmodule

// File: tb/tb_calc_mem_bridge.sv
// Scoreboard bench for calc_mem_bridge: read expectations are queued on issue
// and checked when the registered read data appears.
module tb_calc_mem_bridge;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    calc_mem_bridge_if bus ();

    calc_mem_bridge dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string       tag;
        logic [31:0] data;
    } exp_t;

    exp_t ps_q[$];
    exp_t pl_q[$];
    exp_t ps_e, pl_e;
    logic ps_pend, pl_pend;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [31:0] st(input logic [5:0] mask, input logic rdy, input logic dn);
        return {22'd0, dn, rdy, 2'b00, mask};
    endfunction

    // Output monitor: a read issued before this edge must show its data 1 cycle later.
    always begin
        @(posedge clk);
        ps_pend = bus.ps_rd_en && rst;
        pl_pend = (bus.cmd == 3'd3) && rst;
        #1;
        if (ps_pend) begin
            if (ps_q.size() == 0) check_eq("ps_q_underflow", 32'd1, 32'd0);
            else begin
                ps_e = ps_q.pop_front();
                check_eq(ps_e.tag, bus.ps_rdata, ps_e.data);
            end
        end
        if (pl_pend) begin
            if (pl_q.size() == 0) check_eq("pl_q_underflow", 32'd1, 32'd0);
            else begin
                pl_e = pl_q.pop_front();
                check_eq(pl_e.tag, bus.data_out, pl_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ps_write(input logic [7:0] a, input logic [31:0] d);
        bus.ps_wr_en = 1'b1;
        bus.ps_addr  = a;
        bus.ps_wdata = d;
        tick();
        bus.ps_wr_en = 1'b0;
    endtask

    task automatic ps_read(input string tag, input logic [7:0] a, input logic [31:0] exp);
        bus.ps_rd_en = 1'b1;
        bus.ps_addr  = a;
        ps_q.push_back('{tag, exp});
        tick();
        bus.ps_rd_en = 1'b0;
    endtask

    task automatic pl_write(input logic [7:0] a, input logic [31:0] d);
        bus.cmd        = 3'd2;
        bus.address_pl = a;
        bus.data_pl    = d;
        tick();
        bus.cmd = 3'd4;
    endtask

    task automatic pl_read(input string tag, input logic [7:0] a, input logic [31:0] exp);
        bus.cmd        = 3'd3;
        bus.address_pl = a;
        pl_q.push_back('{tag, exp});
        tick();
        bus.cmd = 3'd4;
    endtask

    task automatic pulse_start();
        bus.ps_start = 1'b1;
        tick();
        bus.ps_start = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.ps_clear = 1'b1;
        tick();
        bus.ps_clear = 1'b0;
    endtask

    task automatic load_all();
        ps_write(8'd255, 32'h1234_5678);
        for (int k = 1; k <= 5; k++) ps_write(8'(k), 32'(k - 1));
        tick();
    endtask

    initial begin
        bus.ps_wr_en = 1'b0; bus.ps_addr = '0; bus.ps_wdata = '0; bus.ps_rd_en = 1'b0;
        bus.ps_start = 1'b0; bus.ps_clear = 1'b0; bus.cmd = 3'd4;
        bus.address_pl = '0; bus.data_pl = '0; bus.done_pl = 1'b0;

        repeat (3) tick();
        check_eq("rst_ready", 32'(bus.ready), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_ps_rdata", bus.ps_rdata, 32'd0);
        check_eq("rst_data_out", bus.data_out, 32'd0);
        rst = 1'b1;
        tick();

        // Load sequence and arm
        ps_write(8'd0, 32'hFFFF_FFFF);
        ps_read("status_empty", 8'd0, st(6'h00, 1'b0, 1'b0));
        ps_write(8'd255, 32'h1234_5678);
        ps_read("status_opnd", 8'd0, st(6'h20, 1'b0, 1'b0));
        for (int k = 1; k <= 5; k++) ps_write(8'(k), 32'(k - 1));
        ps_read("status_loaded", 8'd0, st(6'h3F, 1'b0, 1'b0));
        check_eq("armed_ready", 32'(bus.ready), 32'd0);
        pulse_start();
        check_eq("run_ready", 32'(bus.ready), 32'd1);
        check_eq("run_busy", 32'(bus.busy), 32'd1);

        // Calculator traffic during RUN
        pl_read("pl_opnd", 8'd255, 32'h1234_5678);
        for (int k = 6; k <= 10; k++) pl_write(8'(k), 32'hA0 + 32'(k));
        bus.cmd = 3'd2; bus.address_pl = 8'd6; bus.data_pl = 32'h0000_00AB;
        bus.ps_rd_en = 1'b1; bus.ps_addr = 8'd6;
        ps_q.push_back('{"ps_rd_old_word", 32'h0000_00A6});
        tick();
        bus.cmd = 3'd4; bus.ps_rd_en = 1'b0;
        pl_read("pl_rd6", 8'd6, 32'h0000_00AB);
        for (int k = 7; k <= 10; k++) pl_read($sformatf("pl_b2b_%0d", k), 8'(k), 32'hA0 + 32'(k));
        ps_write(8'd1, 32'd7);
        check_eq("run_busy_hold", 32'(bus.busy), 32'd1);

        // Finish the run
        bus.done_pl = 1'b1;
        tick();
        bus.done_pl = 1'b0;
        check_eq("done_ready", 32'(bus.ready), 32'd0);
        check_eq("done_busy", 32'(bus.busy), 32'd0);
        ps_read("status_done", 8'd0, st(6'h3F, 1'b0, 1'b1));
        ps_read("ps_res6", 8'd6, 32'h0000_00AB);
        for (int k = 7; k <= 10; k++) ps_read($sformatf("ps_res%0d", k), 8'(k), 32'hA0 + 32'(k));
        ps_read("ps_mem1_kept", 8'd1, 32'd0);
        pulse_start();
        check_eq("done_start_ignored", 32'(bus.ready), 32'd0);
        pulse_clear();
        ps_read("status_cleared", 8'd0, st(6'h00, 1'b0, 1'b0));

        // done_pl already high on entry: exactly one cycle of ready
        load_all();
        bus.done_pl = 1'b1;
        pulse_start();
        check_eq("early_done_ready1", 32'(bus.ready), 32'd1);
        tick();
        check_eq("early_done_ready0", 32'(bus.ready), 32'd0);
        bus.done_pl = 1'b0;
        ps_read("status_early_done", 8'd0, st(6'h3F, 1'b0, 1'b1));
        pulse_clear();

        // Abort mid-RUN
        load_all();
        pulse_start();
        check_eq("abort_pre_ready", 32'(bus.ready), 32'd1);
        pulse_clear();
        check_eq("abort_ready", 32'(bus.ready), 32'd0);
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        ps_read("status_abort", 8'd0, st(6'h00, 1'b0, 1'b0));

        // Partial reload: start must be ignored
        ps_write(8'd255, 32'h1234_5678);
        for (int k = 1; k <= 4; k++) ps_write(8'(k), 32'(k - 1));
        tick();
        ps_read("status_partial", 8'd0, st(6'h2F, 1'b0, 1'b0));
        pulse_start();
        check_eq("partial_start_ready", 32'(bus.ready), 32'd0);
        check_eq("partial_start_busy", 32'(bus.busy), 32'd0);

        // PS/PL write collision in IDLE
        bus.ps_wr_en = 1'b1; bus.ps_addr = 8'd20; bus.ps_wdata = 32'h1;
        bus.cmd = 3'd2; bus.address_pl = 8'd20; bus.data_pl = 32'h2;
        tick();
        bus.ps_wr_en = 1'b0; bus.cmd = 3'd4;
        ps_read("ps_collide20", 8'd20, 32'h2);
        pl_read("pl_collide20", 8'd20, 32'h2);

        // Start and clear together in ARMED
        ps_write(8'd5, 32'd4);
        tick();
        ps_read("status_rearmed", 8'd0, st(6'h3F, 1'b0, 1'b0));
        bus.ps_start = 1'b1; bus.ps_clear = 1'b1;
        tick();
        bus.ps_start = 1'b0; bus.ps_clear = 1'b0;
        check_eq("clr_start_ready", 32'(bus.ready), 32'd0);
        tick();
        check_eq("clr_start_busy", 32'(bus.busy), 32'd0);
        ps_read("status_clr_start", 8'd0, st(6'h00, 1'b0, 1'b0));

        repeat (2) tick();
        check_eq("ps_q_drained", 32'(ps_q.size()), 32'd0);
        check_eq("pl_q_drained", 32'(pl_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/calc_mem_bridge.md
Name: calc_mem_bridge

Overview:
Shared 256x32 word memory between the PS register interface and the PL matrix calculator. The PS writes the packed operand word to mem[255] and five 3-bit opcodes to mem[1..5]. The calculator reads and writes the memory through its cmd/address_pl/data_pl port, placing its results in mem[6..10]. The block sequences the run: it raises ready to the calculator once all inputs are loaded and the PS issues start, and it locks out PS writes while the calculator is running.

Parameters:
DEPTH, 256, number of 32-bit words; address width is 8 bits
OPND_ADDR, 8'd255, address of the packed operand word
N_INSTR, 5, number of opcode slots at mem[1..N_INSTR]

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
ps_wr_en  in  1  PS write strobe, one word per cycle
ps_addr  in  8  PS read/write address
ps_wdata  in  32  PS write data
ps_rd_en  in  1  PS read strobe
ps_rdata  out  32  PS read data
ps_start  in  1  single-cycle pulse: start the run
ps_clear  in  1  single-cycle pulse: abort the run / re-arm
cmd  in  3  calculator command: 3'd2 write, 3'd3 read, 3'd4 idle; all other codes treated as idle
address_pl  in  8  calculator address
data_pl  in  32  calculator write data
data_out  out  32  read data to the calculator (its data_in)
done_pl  in  1  calculator finished (level)
ready  out  1  inputs valid; calculator may run
busy  out  1  high in RUN; PS writes are dropped

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, load mask=0, ready=0, busy=0, ps_rdata=0, data_out=0. Memory contents are not cleared.
- Load mask (6 bits):
  - bit k-1 is set when the PS makes an accepted write to mem[k], k=1..5.
  - bit5 is set when the PS makes an accepted write to mem[255].
  - The mask is cleared only by reset or ps_clear.
- PS writes:
  - Accepted in IDLE, ARMED and DONE; dropped in RUN.
  - Writes to address 0 are always dropped (status word is read-only).
- PS reads:
  - ps_rdata is registered and updates 1 cycle after ps_rd_en; otherwise it holds its value.
  - Address 0 returns the status word: [5:0]=mask, [8]=ready, [9]=state==DONE, all other bits 0.
  - Any other address returns mem[addr].
- Calculator port (honoured in every state):
  - cmd=2: mem[address_pl] <= data_pl at that edge.
  - cmd=3: data_out <= mem[address_pl] at that edge, i.e. 1-cycle latency. Back-to-back reads give one word per cycle.
  - Other cmd codes: data_out holds its value.
  - A read of the address being written in the same cycle returns the old word.
- Write collision (same address, same cycle, PS and PL): the PL write wins. This can only occur outside RUN.
- FSM:
  - IDLE -> ARMED when mask==6'h3F.
  - ARMED -> RUN on ps_start; ready=1 and busy=1 from the next cycle.
  - ps_start in IDLE, RUN or DONE is ignored.
  - RUN -> DONE when done_pl==1 is sampled; ready=0 and busy=0 from the next cycle.
  - DONE holds until ps_clear.
  - ps_clear in any state -> IDLE and mask=0 next cycle. This includes an abort mid-RUN, which drops ready immediately.
  - ps_clear together with ps_start in the same cycle: clear wins.
  - done_pl already high when RUN is entered: leave RUN after exactly one cycle of ready=1.
- ready and busy are registered outputs, with no combinational path from any input.

Test Plan:
- Reset, then PS writes mem[255]=32'h1234_5678 and mem[1..5]=0,1,2,3,4 -> status reads 6'h3F with ready=0; ps_start -> ready=1 and busy=1 on the following cycle.
- In RUN: cmd=3, address_pl=255 -> data_out=32'h1234_5678 one cycle later; cmd=2, address_pl=6, data_pl=32'h0000_00AB, then a read of 6 -> 32'h0000_00AB.
- In RUN: PS writes mem[1]=7 -> dropped; after the run, a PS read of mem[1] returns 0.
- done_pl raised -> ready=0 next cycle; status bit9=1; PS reads of mem[6..10] return the calculator results.
- ps_clear mid-RUN -> ready=0 next cycle, mask=0, state IDLE; ps_start before reloading all six words -> ignored (ready stays 0).
- In IDLE, PS and PL write address 20 in the same cycle (32'h1 and 32'h2) -> mem[20]=32'h2; ps_start together with ps_clear in ARMED -> IDLE, ready stays 0.
